// File: rtl/memory_stage.sv
// Memory pipeline stage: M register, data-bus access FSM, store lane steering and load alignment/extension.
// Latency: one registered stage; a memory access stalls at least one cycle (ack in the first request cycle).
// Backpressure: stall_M holds upstream stages and the M register until the bus access has completed.
module memory_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_result_E,
    input  logic [31:0] write_data_E,
    input  logic [2:0]  funct3_E,
    input  logic [1:0]  wb_ctrl_E,
    input  logic        mem_write_E,
    input  logic        reg_write_E,
    input  logic [4:0]  rd_E,
    input  logic        flush_M,
    output logic [31:0] ALU_result_M,
    output logic [1:0]  wb_ctrl_M,
    output logic [4:0]  rd_M,
    output logic        reg_write_M,
    output logic [31:0] Rdata_ext_M,
    output logic        stall_M,
    output logic        misalign_M,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_nxt;
    logic [31:0] write_data_q;
    logic [2:0]  funct3_q;
    logic        mem_write_q;
    logic        reg_write_q;
    logic [31:0] load_buf_q;
    logic        mem_op;
    logic        bad_access;
    logic        aligned_op;
    logic [31:0] rdata_shift;
    logic [31:0] rdata_ext;

    // M register: hold while stalled, bubble on flush, otherwise take the execute-stage values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_result_M <= '0;
            write_data_q <= '0;
            funct3_q     <= '0;
            wb_ctrl_M    <= '0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_M         <= '0;
        end else if (!stall_M) begin
            if (flush_M) begin
                ALU_result_M <= '0;
                write_data_q <= '0;
                funct3_q     <= '0;
                wb_ctrl_M    <= '0;
                mem_write_q  <= 1'b0;
                reg_write_q  <= 1'b0;
                rd_M         <= '0;
            end else begin
                ALU_result_M <= ALU_result_E;
                write_data_q <= write_data_E;
                funct3_q     <= funct3_E;
                wb_ctrl_M    <= wb_ctrl_E;
                mem_write_q  <= mem_write_E;
                reg_write_q  <= reg_write_E;
                rd_M         <= rd_E;
            end
        end
    end

    // Classify the M instruction: is it a memory op, and is its width/alignment legal.
    always_comb begin
        mem_op = (wb_ctrl_M == 2'b01) || mem_write_q;
        unique case (funct3_q)
            3'b000, 3'b100: bad_access = 1'b0;
            3'b001, 3'b101: bad_access = ALU_result_M[0];
            3'b010:         bad_access = (ALU_result_M[1:0] != 2'b00);
            default:        bad_access = 1'b1;
        endcase
        misalign_M  = mem_op && bad_access;
        aligned_op  = mem_op && !bad_access;
        stall_M     = aligned_op && (state_q != DONE);
        reg_write_M = reg_write_q && !misalign_M;
    end

    // Access FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Access FSM next state and bus request; ack is only honoured while a request is out.
    always_comb begin
        state_nxt = state_q;
        dbus_req  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    dbus_req  = 1'b1;
                    state_nxt = dbus_ack ? DONE : BUSY;
                end
            end
            BUSY: begin
                dbus_req = 1'b1;
                if (dbus_ack) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus address, lane enables and lane-replicated store data, all derived from the held M register.
    always_comb begin
        dbus_we   = mem_write_q;
        dbus_addr = {ALU_result_M[31:2], 2'b00};
        unique case (funct3_q[1:0])
            2'b00: begin
                dbus_be    = 4'b0001 << ALU_result_M[1:0];
                dbus_wdata = {4{write_data_q[7:0]}};
            end
            2'b01: begin
                dbus_be    = 4'b0011 << ALU_result_M[1:0];
                dbus_wdata = {2{write_data_q[15:0]}};
            end
            default: begin
                dbus_be    = 4'b1111;
                dbus_wdata = write_data_q;
            end
        endcase
    end

    // Align the returned word to the addressed byte and sign/zero-extend to 32 bits.
    always_comb begin
        rdata_shift = dbus_rdata >> {ALU_result_M[1:0], 3'b000};
        unique case (funct3_q)
            3'b000:  rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  rdata_ext = {24'd0, rdata_shift[7:0]};
            3'b101:  rdata_ext = {16'd0, rdata_shift[15:0]};
            default: rdata_ext = rdata_shift;
        endcase
    end

    // Load buffer: captured on the ack cycle of an outstanding load request only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                load_buf_q <= '0;
        else if (dbus_req && dbus_ack && !mem_write_q) load_buf_q <= rdata_ext;
    end

    assign Rdata_ext_M = load_buf_q;

endmodule
